// File: rtl/if_id_fetch_stage_if.sv
// Bus between the fetch stage and its surroundings: hazard-unit controls,
// branch redirect from ID, instruction memory port and the IF/ID outputs.
interface if_id_fetch_stage_if #(
  parameter int STALL_CW = 8
);
  logic                pc_enable;
  logic                load_enable;
  logic                flush;
  logic                branch_taken;
  logic [31:0]         branch_target;
  logic [31:0]         imem_instr;
  logic [31:0]         imem_addr;
  logic [31:0]         id_instr;
  logic [31:0]         id_pc;
  logic                id_valid;
  logic [STALL_CW-1:0] stall_count;
  logic                protocol_error;

  // Environment side: drives controls and memory data, observes the stage.
  modport master (
    output pc_enable, load_enable, flush, branch_taken, branch_target, imem_instr,
    input  imem_addr, id_instr, id_pc, id_valid, stall_count, protocol_error
  );

  // Fetch stage side.
  modport slave (
    input  pc_enable, load_enable, flush, branch_taken, branch_target, imem_instr,
    output imem_addr, id_instr, id_pc, id_valid, stall_count, protocol_error
  );
endinterface

// File: rtl/if_id_fetch_stage.sv
// Fetch stage + IF/ID register with MIPS-style PC/nPC delay-slot model.
// PC and IF/ID obey the hazard unit's enables independently; illegal enable
// pairs and misaligned branch targets raise a sticky protocol_error.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int          STALL_CW = 8
) (
  input logic                clk,
  input logic                reset_n,
  if_id_fetch_stage_if.slave bus
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, STALL = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [31:0]         pc_q, pc_d, npc_q, npc_d;
  logic [31:0]         id_instr_q, id_instr_d, id_pc_q, id_pc_d;
  logic                id_valid_q, id_valid_d;
  logic [STALL_CW-1:0] stall_count_q, stall_count_d;
  logic                perr_q, perr_d;

  // control decoded from state
  logic advance, load_ifid, use_branch, check_en, cnt_inc, cnt_clr;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= BOOT;
    else          state_q <= state_d;
  end

  // Next-state: BOOT runs exactly one cycle; STALL left only when PC may move
  always_comb begin
    state_d = BOOT;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = (!bus.pc_enable && !bus.load_enable) ? STALL : RUN;
      STALL:   state_d = bus.pc_enable ? RUN : STALL;
      default: state_d = BOOT;
    endcase
  end

  // Output decode: BOOT forces one fetch and ignores the hazard unit
  always_comb begin
    advance    = 1'b0;
    load_ifid  = 1'b0;
    use_branch = 1'b0;
    check_en   = 1'b0;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    case (state_q)
      BOOT: begin
        advance   = 1'b1;
        load_ifid = 1'b1;
        cnt_clr   = 1'b1;
      end
      RUN: begin
        advance    = bus.pc_enable;
        load_ifid  = bus.load_enable;
        use_branch = bus.pc_enable & bus.branch_taken;
        check_en   = 1'b1;
        cnt_inc    = !bus.pc_enable && !bus.load_enable;
      end
      STALL: begin
        advance    = bus.pc_enable;
        load_ifid  = bus.load_enable;
        use_branch = bus.pc_enable & bus.branch_taken;
        check_en   = 1'b1;
        cnt_inc    = !bus.pc_enable;
        cnt_clr    = bus.pc_enable;
      end
      default: ;
    endcase
  end

  // Datapath next values: PC/nPC, IF/ID, stall counter, sticky error
  always_comb begin
    pc_d          = pc_q;
    npc_d         = npc_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_valid_d    = id_valid_q;
    stall_count_d = stall_count_q;
    perr_d        = perr_q;

    if (advance) begin
      pc_d  = npc_q;
      npc_d = use_branch ? {bus.branch_target[31:2], 2'b00} : npc_q + 32'd4;
    end

    // flush annuls even when IF/ID would otherwise hold or load
    if (bus.flush) begin
      id_instr_d = NOP_WORD;
      id_valid_d = 1'b0;
    end else if (load_ifid) begin
      id_instr_d = bus.imem_instr;
      id_pc_d    = pc_q;
      id_valid_d = 1'b1;
    end

    if (cnt_clr)
      stall_count_d = '0;
    else if (cnt_inc && !(&stall_count_q))
      stall_count_d = stall_count_q + 1'b1;

    if (check_en && ((bus.pc_enable ^ bus.load_enable) ||
                     (use_branch && (bus.branch_target[1:0] != 2'b00))))
      perr_d = 1'b1;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      npc_q         <= RESET_PC + 32'd4;
      id_instr_q    <= NOP_WORD;
      id_pc_q       <= '0;
      id_valid_q    <= 1'b0;
      stall_count_q <= '0;
      perr_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      npc_q         <= npc_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_valid_q    <= id_valid_d;
      stall_count_q <= stall_count_d;
      perr_q        <= perr_d;
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.id_instr       = id_instr_q;
  assign bus.id_pc          = id_pc_q;
  assign bus.id_valid       = id_valid_q;
  assign bus.stall_count    = stall_count_q;
  assign bus.protocol_error = perr_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Scoreboard bench for if_id_fetch_stage: the driver updates a behavioural
// model each cycle and queues the expected outputs; the monitor compares after
// every rising edge.
module tb_if_id_fetch_stage;
  localparam int          CW   = 2;
  localparam logic [31:0] RPC  = 32'h0000_0100;
  localparam logic [31:0] NOP  = 32'hFFFF_0000;
  localparam int          CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  if_id_fetch_stage_if #(.STALL_CW(CW)) bus();

  if_id_fetch_stage #(.RESET_PC(RPC), .NOP_WORD(NOP), .STALL_CW(CW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  // distinct word per address so any fetch from a wrong address is visible
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction
  always_comb bus.imem_instr = imem(bus.imem_addr);

  typedef struct {
    logic [31:0] addr, instr, pc;
    logic valid;
    logic [CW-1:0] cnt;
    logic perr;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [31:0] m_pc, m_npc, m_instr, m_idpc;
  bit m_valid, m_perr, m_boot;
  int m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // monitor: one expected entry per clock, checked just after the edge
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("imem_addr", bus.imem_addr, mon_e.addr);
      chk("id_instr", bus.id_instr, mon_e.instr);
      chk("id_pc", bus.id_pc, mon_e.pc);
      chk("id_valid", 32'(bus.id_valid), 32'(mon_e.valid));
      chk("stall_count", 32'(bus.stall_count), 32'(mon_e.cnt));
      chk("protocol_error", 32'(bus.protocol_error), 32'(mon_e.perr));
    end
  end

  // one cycle of stimulus; the model describes what the stage must show
  // after the coming rising edge
  task automatic step(input bit rst, input bit pe, input bit le, input bit fl,
                      input bit bt, input logic [31:0] tgt);
    bit p, l, b;
    @(negedge clk);
    reset_n           = !rst;
    bus.pc_enable     = pe;
    bus.load_enable   = le;
    bus.flush         = fl;
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
    if (rst) begin
      m_pc = RPC; m_npc = RPC + 32'd4; m_instr = NOP; m_idpc = '0;
      m_valid = 0; m_cnt = 0; m_perr = 0; m_boot = 1;
    end else begin
      p = pe; l = le; b = bt;
      if (m_boot) begin p = 1; l = 1; b = 0; end
      if ((p != l) || (p && b && tgt[1:0] != 2'b00)) m_perr = 1;
      // a nonzero count means a stall is in progress
      if (p) m_cnt = 0;
      else if (!l || m_cnt != 0) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
      if (fl) begin m_instr = NOP; m_valid = 0; end
      else if (l) begin m_instr = imem(m_pc); m_idpc = m_pc; m_valid = 1; end
      if (p) begin
        m_pc  = m_npc;
        m_npc = b ? {tgt[31:2], 2'b00} : m_npc + 32'd4;
      end
      m_boot = 0;
    end
    q.push_back('{m_pc, m_instr, m_idpc, m_valid, CW'(m_cnt), m_perr});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1, 0, 0, 32'h0);
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    bit r, pe, le, fl, bt;
    logic [31:0] tgt;
    bus.pc_enable = 0; bus.load_enable = 0; bus.flush = 0;
    bus.branch_taken = 0; bus.branch_target = '0;

    // reset, boot, straight-line fetch from 0x100
    step(1, 0, 0, 0, 0, 0); step(1, 1, 1, 0, 0, 0);
    run(4);

    // redirect to 0x10, then a 3-cycle load-use stall there
    step(0, 1, 1, 0, 1, 32'h10); run(1);
    stall(3); run(2);

    // branch fetched at 0x20 to 0x80: delay slot 0x24, then 0x80, 0x84
    step(0, 1, 1, 0, 1, 32'h1C); run(2);
    step(0, 1, 1, 0, 1, 32'h80); run(3);

    // flush while loading: NOP enters IF/ID, PC still advances
    step(0, 1, 1, 1, 0, 0); run(1);
    // flush during stall
    stall(1); step(0, 0, 0, 1, 0, 0); run(1);

    // address wrap past 0xFFFF_FFFC
    step(0, 1, 1, 0, 1, 32'hFFFF_FFF8); run(4);

    // illegal pair (0,1), sticky error, then misaligned target 0x83
    step(0, 0, 1, 0, 0, 0); run(2);
    step(0, 1, 0, 0, 0, 0); run(1);
    step(0, 1, 1, 0, 1, 32'h83); run(3);

    // saturating count over a 5-cycle stall, then reset mid-stall
    step(1, 0, 0, 0, 0, 0); run(3);
    stall(5); run(1);
    stall(2); step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0); run(3);

    // reset mid-branch
    step(0, 1, 1, 0, 1, 32'h400); step(1, 1, 1, 0, 0, 0); run(3);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom % 100) == 0;
      pe  = ($urandom % 3) != 0;
      le  = (($urandom % 16) == 0) ? !pe : pe;
      fl  = ($urandom % 10) == 0;
      bt  = ($urandom % 5) == 0;
      tgt = $urandom;
      if (($urandom % 4) != 0) tgt[1:0] = 2'b00;
      step(r, pe, le, fl, bt, tgt);
    end

    repeat (2) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
